// File: rtl/pc_spi_word_gate.sv
// pc_spi_word_gate: filters SPI-assembled {cmd, data} words into the PC-to-bus FIFO,
// enforcing command legality, ADDR-first sequencing and a fill margin, with sticky faults.
module pc_spi_word_gate #(
    parameter int FIFO_DEPTH  = 2048,
    parameter int USEDW_WIDTH = 11,
    parameter int FULL_MARGIN = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_ftdi_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_word_valid,
    input  logic [7:0]             i_word_cmd,
    input  logic [31:0]            i_word_data,
    input  logic [USEDW_WIDTH-1:0] i_fifo_wrusedw,
    output logic                   o_fifo_wrreq,
    output logic [39:0]            o_fifo_data,
    output logic [CNT_WIDTH-1:0]   o_drop_count,
    output logic                   o_err_overflow,
    output logic                   o_err_illegal,
    output logic                   o_err_sequence,
    output logic [1:0]             o_state
);
    typedef enum logic [1:0] {
        S_NO_ADDR    = 2'd0,
        S_ADDR_VALID = 2'd1,
        S_LOCKED     = 2'd2,
        S_UNUSED     = 2'd3
    } state_t;

    localparam int OW = USEDW_WIDTH + 1;
    localparam logic [OW-1:0] LIMIT = OW'(FIFO_DEPTH - FULL_MARGIN);

    state_t               state_q, state_d;
    logic                 wrreq_q, wrreq_d;
    logic [39:0]          data_q, data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, ill_q, ill_d, seq_q, seq_d;
    logic [OW-1:0]        occ;
    logic                 full, legal_cmd, bad_payload, needs_addr, drop;

    // usedw lags our own write by a cycle, so the in-flight word is added back in
    assign occ         = {1'b0, i_fifo_wrusedw} + OW'(wrreq_q);
    assign full        = occ >= LIMIT;
    assign legal_cmd   = i_word_cmd == 8'h10 || i_word_cmd == 8'h20 || i_word_cmd == 8'h30 ||
                         i_word_cmd == 8'h40 || i_word_cmd == 8'hFC;
    assign bad_payload = i_word_cmd == 8'h30 && i_word_data[31:24] != 8'h00;
    assign needs_addr  = (i_word_cmd == 8'h30 || i_word_cmd == 8'h40) && state_q != S_ADDR_VALID;

    always_comb begin
        state_d = (state_q == S_UNUSED) ? S_NO_ADDR : state_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        seq_d   = seq_q;
        drop    = 1'b0;
        if (i_word_valid) begin
            if (state_q == S_LOCKED) begin
                drop = 1'b1;
            end else if (!legal_cmd || bad_payload) begin
                drop  = 1'b1;
                ill_d = 1'b1;
            end else if (needs_addr) begin
                drop  = 1'b1;
                seq_d = 1'b1;
            end else if (full) begin
                drop    = 1'b1;
                ovf_d   = 1'b1;
                state_d = S_LOCKED;
            end else begin
                wrreq_d = 1'b1;
                data_d  = {i_word_cmd, i_word_data};
                state_d = (i_word_cmd == 8'h20) ? S_ADDR_VALID :
                          (i_word_cmd == 8'hFC) ? S_NO_ADDR : state_d;
            end
        end
        cnt_d = (drop && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge i_ftdi_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_NO_ADDR;
            wrreq_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else if (i_clear) begin
            state_q <= S_NO_ADDR;
            wrreq_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
        end
    end

    assign o_fifo_wrreq   = wrreq_q;
    assign o_fifo_data    = data_q;
    assign o_drop_count   = cnt_q;
    assign o_err_overflow = ovf_q;
    assign o_err_illegal  = ill_q;
    assign o_err_sequence = seq_q;
    assign o_state        = state_q;
endmodule

// File: tb/tb_pc_spi_word_gate.sv
// tb_pc_spi_word_gate: directed vector table plus hand sequences for async reset
// and counter saturation (a narrow-counter instance reaches all-ones quickly).
module tb_pc_spi_word_gate;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  cmd = '0;
    logic [31:0] data = '0;
    logic [10:0] usedw = '0;
    logic        wrreq, ovf, ill, seq;
    logic [39:0] fdata;
    logic [15:0] cnt;
    logic [1:0]  state;
    logic        s_wrreq, s_ovf, s_ill, s_seq;
    logic [39:0] s_fdata;
    logic [1:0]  s_cnt, s_state;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_spi_word_gate dut (
        .i_ftdi_clk(clk), .i_reset(rst), .i_clear(clr), .i_word_valid(valid),
        .i_word_cmd(cmd), .i_word_data(data), .i_fifo_wrusedw(usedw),
        .o_fifo_wrreq(wrreq), .o_fifo_data(fdata), .o_drop_count(cnt),
        .o_err_overflow(ovf), .o_err_illegal(ill), .o_err_sequence(seq), .o_state(state)
    );

    pc_spi_word_gate #(.CNT_WIDTH(2)) u_sat (
        .i_ftdi_clk(clk), .i_reset(rst), .i_clear(clr), .i_word_valid(valid),
        .i_word_cmd(cmd), .i_word_data(data), .i_fifo_wrusedw(usedw),
        .o_fifo_wrreq(s_wrreq), .o_fifo_data(s_fdata), .o_drop_count(s_cnt),
        .o_err_overflow(s_ovf), .o_err_illegal(s_ill), .o_err_sequence(s_seq), .o_state(s_state)
    );

    typedef struct {
        logic        v;
        logic        c;
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [10:0] usedw;
        logic        wrreq;
        logic [39:0] fdata;
        logic [1:0]  state;
        logic [15:0] cnt;
        logic [2:0]  flags;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic [7:0] k,
                        input logic [31:0] d, input logic [10:0] u);
        valid = v; clr = c; cmd = k; data = d; usedw = u;
        @(posedge clk);
        #1;
        valid = 1'b0; clr = 1'b0;
    endtask

    task automatic add(input logic v, input logic c, input logic [7:0] k, input logic [31:0] d,
                       input logic [10:0] u, input logic w, input logic [39:0] fd,
                       input logic [1:0] st, input logic [15:0] n, input logic [2:0] f);
        vecs.push_back('{v, c, k, d, u, w, fd, st, n, f});
    endtask

    initial begin
        // flags column is {overflow, illegal, sequence}
        add(1,0,8'h20,32'h00001000,0,    1,40'h2000001000,1,0,3'b000);
        add(1,0,8'h40,32'hDEADBEEF,0,    1,40'h40DEADBEEF,1,0,3'b000);
        add(0,0,8'h00,32'h0,       0,    0,40'h40DEADBEEF,1,0,3'b000);
        add(1,0,8'h10,32'h00000005,0,    1,40'h1000000005,1,0,3'b000);
        add(1,0,8'hFC,32'h0,       0,    1,40'hFC00000000,0,0,3'b000);
        add(1,0,8'h40,32'h12345678,0,    0,40'hFC00000000,0,1,3'b001);
        add(1,0,8'h30,32'h00000010,0,    0,40'hFC00000000,0,2,3'b001);
        add(1,0,8'h20,32'h0,       0,    1,40'h2000000000,1,2,3'b001);
        add(1,0,8'h50,32'h0,       0,    0,40'h2000000000,1,3,3'b011);
        add(1,0,8'h30,32'h01000000,0,    0,40'h2000000000,1,4,3'b011);
        add(1,0,8'h30,32'h00FFFFFF,0,    1,40'h3000FFFFFF,1,4,3'b011);
        add(0,1,8'h00,32'h0,       0,    0,40'h3000FFFFFF,0,0,3'b000);
        add(1,0,8'h20,32'h0,       2043, 1,40'h2000000000,1,0,3'b000);
        add(1,0,8'h40,32'h00000011,2043, 0,40'h2000000000,2,1,3'b100);
        add(1,0,8'h10,32'h0,       0,    0,40'h2000000000,2,2,3'b100);
        add(1,0,8'h50,32'h0,       0,    0,40'h2000000000,2,3,3'b100);
        add(1,1,8'h20,32'h00000007,0,    0,40'h2000000000,0,0,3'b000);
        add(1,0,8'h20,32'h00000007,0,    1,40'h2000000007,1,0,3'b000);
        add(0,0,8'h00,32'h0,       0,    0,40'h2000000007,1,0,3'b000);
        add(1,0,8'h10,32'h00000001,2044, 0,40'h2000000007,2,1,3'b100);
        add(0,1,8'h00,32'h0,       0,    0,40'h2000000007,0,0,3'b000);
        add(1,0,8'h30,32'h01000000,0,    0,40'h2000000007,0,1,3'b010);
        add(1,0,8'hFF,32'h0,       0,    0,40'h2000000007,0,2,3'b010);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wrreq", 64'(wrreq), 64'd0);
        chk("reset_data", 64'(fdata), 64'd0);
        chk("reset_cnt", 64'(cnt), 64'd0);
        chk("reset_flags", 64'({ovf, ill, seq}), 64'd0);
        chk("reset_state", 64'(state), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].c, vecs[i].cmd, vecs[i].data, vecs[i].usedw);
            chk($sformatf("v%0d_wrreq", i), 64'(wrreq), 64'(vecs[i].wrreq));
            chk($sformatf("v%0d_data", i), 64'(fdata), 64'(vecs[i].fdata));
            chk($sformatf("v%0d_state", i), 64'(state), 64'(vecs[i].state));
            chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_flags", i), 64'({ovf, ill, seq}), 64'(vecs[i].flags));
        end

        // asynchronous reset kills a pending write without waiting for an edge
        step(1, 0, 8'h20, 32'hA5A5A5A5, 0);
        chk("pre_rst_wrreq", 64'(wrreq), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wrreq", 64'(wrreq), 64'd0);
        chk("async_rst_data", 64'(fdata), 64'd0);
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_flags", 64'({ovf, ill, seq, 2'b00} | 5'(cnt)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2-bit counter saturates at 3 while the 16-bit one keeps counting
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'h55, 32'h0, 0);
            chk($sformatf("sat%0d_cnt", i), 64'(s_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
            chk($sformatf("sat%0d_main_cnt", i), 64'(cnt), 64'(i + 1));
        end
        chk("sat_ill", 64'(s_ill), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_spi_word_gate.md
Name: pc_spi_word_gate

Overview:
- Sits in the i_ftdi_clk domain between the SPI deserializer and the write port of the PC-to-bus FIFO.
- Receives assembled 40-bit {cmd, data} words and forwards only legal, correctly sequenced words to the FIFO.
- Applies a full-margin check against FIFO fill level; drops rejected words.
- Reports sticky error flags and a saturating drop counter so the SPI status path can surface protocol faults to the PC.

Parameters:
- FIFO_DEPTH, 2048, word capacity of the downstream FIFO.
- USEDW_WIDTH, 11, width of the FIFO write-side used-words count.
- FULL_MARGIN, 4, free words kept in reserve; a word is rejected when the FIFO is within this margin of full.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- i_ftdi_clk  in  1  SPI clock; all logic is on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous clear of state, flags and counter (driven by the SPI-reset / flush-write command).
- i_word_valid  in  1  one-cycle strobe: word complete.
- i_word_cmd  in  8  command byte of the word.
- i_word_data  in  32  payload of the word.
- i_fifo_wrusedw  in  USEDW_WIDTH  FIFO write-side fill level.
- o_fifo_wrreq  out  1  FIFO write strobe.
- o_fifo_data  out  40  {cmd, data} to FIFO.
- o_drop_count  out  CNT_WIDTH  saturating count of rejected words.
- o_err_overflow  out  1  sticky: word rejected for lack of space.
- o_err_illegal  out  1  sticky: non-FIFO command or bad payload.
- o_err_sequence  out  1  sticky: WRITE or READ_LENGTH before ADDR.
- o_state  out  2  current FSM state.

Behaviour:
- Reset (async): o_fifo_wrreq=0, o_fifo_data=0, o_drop_count=0, all err flags=0, state=S_NO_ADDR (2'd0).
- States:
  - S_NO_ADDR=0
  - S_ADDR_VALID=1
  - S_LOCKED=2
  - encoding 3 is unused and recovers to S_NO_ADDR on the next clock.
- Latency: accepted word produces o_fifo_wrreq=1 and o_fifo_data={cmd,data} on the edge after i_word_valid; exactly one cycle. o_fifo_wrreq is deasserted in every other cycle; o_fifo_data holds its last value.
- Space check: let occ = i_fifo_wrusedw + o_fifo_wrreq (previous write not yet reflected). The check is evaluated at USEDW_WIDTH+1 bits.
  - Reject when occ >= FIFO_DEPTH - FULL_MARGIN.
  - On overflow reject: set o_err_overflow and go to S_LOCKED.
- Classification per valid word, priority top-down:
  1. State S_LOCKED -> drop; no new flag set.
  2. cmd not in {0x10, 0x20, 0x30, 0x40, 0xFC} -> drop, set o_err_illegal. State is unchanged.
  3. cmd=0x30 with data[31:24] != 0 -> drop, set o_err_illegal.
  4. cmd in {0x30, 0x40} while in S_NO_ADDR -> drop, set o_err_sequence.
  5. Space check fails -> drop, set o_err_overflow, go to S_LOCKED.
  6. Otherwise accept.
- Accept transitions:
  - 0x20 -> S_ADDR_VALID.
  - 0xFC -> S_NO_ADDR.
  - 0x10, 0x30, 0x40 -> state unchanged.
- Drop counter: +1 on every dropped word, including words dropped in S_LOCKED. Saturates at all-ones; no wrap.
- i_clear:
  - Next edge: state=S_NO_ADDR, flags=0, counter=0, o_fifo_wrreq=0.
  - Takes priority over a simultaneous i_word_valid; that word is discarded and not counted.
- S_LOCKED is left only via i_clear or i_reset. This guarantees no partial write stream reaches the bus after data loss.
- i_word_valid for back-to-back cycles is legal; each word is judged independently, with occ accounting for the previous cycle's write.
- Reset mid-operation: a pending o_fifo_wrreq is cleared immediately (async); the word is lost.

Test Plan:
- Reset, then ADDR 0x00001000, WRITE 0xDEADBEEF, usedw=0 -> two wrreq pulses with data 0x2000001000 then 0x40DEADBEEF; state 0->1; drop_count=0.
- After reset, WRITE 0x12345678 -> no wrreq; o_err_sequence=1; drop_count=1; state=0. Then ADDR 0x0 -> accepted, state=1.
- Send cmd 0x50, then READ_LENGTH with data 0x01000000 -> both dropped; o_err_illegal=1; drop_count=2; state unchanged.
- usedw=2043 (threshold 2044), ADDR then WRITE back-to-back -> ADDR accepted. WRITE sees occ=2044 and is dropped; o_err_overflow=1; state=2. A further CONFIG is dropped; drop_count=2.
- In S_LOCKED, assert i_clear together with i_word_valid (ADDR) -> state=0, all flags=0, drop_count=0, no wrreq. The next ADDR is accepted.
- Force drop_count to 0xFFFE via 3 illegal words after preload -> count saturates at 0xFFFF and stays there.
